// File: rtl/ex_mem_ccr_register_if.sv
// ex_mem_ccr_register_if: execute-to-memory handshake, CCR and jump-predicate signals.
interface ex_mem_ccr_register_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int FLAG_W = 4
);
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] alu_result;
    logic [FLAG_W-1:0] new_status;
    logic [FLAG_W-1:0] flag_mask;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] dst_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              flush;
    logic              int_save;
    logic              rti_restore;
    logic [1:0]        jmp_cond;
    logic              jmp_taken;
    logic              mem_valid;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [REG_AW-1:0] mem_dst_addr;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic [FLAG_W-1:0] ccr;

    modport slave (
        input  ex_valid, alu_result, new_status, flag_mask, store_data, dst_addr,
               reg_write, mem_read, mem_write, flush, int_save, rti_restore,
               jmp_cond, mem_ready,
        output ex_ready, jmp_taken, mem_valid, mem_alu_result, mem_store_data,
               mem_dst_addr, mem_reg_write, mem_mem_read, mem_mem_write, ccr
    );

    modport master (
        output ex_valid, alu_result, new_status, flag_mask, store_data, dst_addr,
               reg_write, mem_read, mem_write, flush, int_save, rti_restore,
               jmp_cond, mem_ready,
        input  ex_ready, jmp_taken, mem_valid, mem_alu_result, mem_store_data,
               mem_dst_addr, mem_reg_write, mem_mem_read, mem_mem_write, ccr
    );
endinterface

// File: rtl/ex_mem_ccr_register.sv
// ex_mem_ccr_register: EX/MEM pipeline register with condition-code register, interrupt shadow and jump predicate.
// Define FLAG_FORWARD_EN to let the jump predicate see flags from a same-cycle accept.
module ex_mem_ccr_register #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int FLAG_W = 4
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    ex_mem_ccr_register_if.slave bus
);
    localparam logic [FLAG_W-1:0] FLAG_LIVE = FLAG_W'(3'b111);

    logic              r_mem_valid;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_AW-1:0] r_dst_addr;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [FLAG_W-1:0] r_ccr;
    logic [FLAG_W-1:0] r_shadow;

    logic              w_ex_ready;
    logic              w_accept;
    logic [FLAG_W-1:0] w_merged;
    logic [FLAG_W-1:0] w_flags;
    logic              w_jmp_taken;
    logic [FLAG_W-1:0] w_clear;
    logic [FLAG_W-1:0] w_ccr_next;

    assign w_ex_ready = !r_mem_valid || bus.mem_ready;
    assign w_accept   = bus.ex_valid && w_ex_ready && !bus.flush;
    assign w_merged   = ((bus.flag_mask & bus.new_status) | (~bus.flag_mask & r_ccr)) & FLAG_LIVE;
`ifdef FLAG_FORWARD_EN
    assign w_flags    = w_accept ? w_merged : r_ccr;
`else
    assign w_flags    = r_ccr;
`endif
    assign w_jmp_taken = (bus.jmp_cond == 2'b11) || w_flags[bus.jmp_cond];
    // A taken conditional jump consumes its flag; restore still wins over the clear.
    assign w_clear    = (w_jmp_taken && bus.jmp_cond != 2'b11) ? FLAG_W'(1) << bus.jmp_cond : '0;
    assign w_ccr_next = bus.rti_restore ? r_shadow : (w_accept ? w_merged : r_ccr) & ~w_clear;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_valid  <= 1'b0;
            r_alu_result <= '0;
            r_store_data <= '0;
            r_dst_addr   <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_ccr        <= '0;
            r_shadow     <= '0;
        end else begin
            r_mem_valid <= bus.flush ? 1'b0 : w_accept ? 1'b1 : bus.mem_ready ? 1'b0 : r_mem_valid;
            if (w_accept) begin
                r_alu_result <= bus.alu_result;
                r_store_data <= bus.store_data;
                r_dst_addr   <= bus.dst_addr;
                r_reg_write  <= bus.reg_write;
                r_mem_read   <= bus.mem_read;
                r_mem_write  <= bus.mem_write;
            end
            r_ccr <= w_ccr_next;
            if (bus.int_save) r_shadow <= r_ccr;
        end
    end

    assign bus.ex_ready       = w_ex_ready;
    assign bus.jmp_taken      = w_jmp_taken;
    assign bus.mem_valid      = r_mem_valid;
    assign bus.mem_alu_result = r_alu_result;
    assign bus.mem_store_data = r_store_data;
    assign bus.mem_dst_addr   = r_dst_addr;
    assign bus.mem_reg_write  = r_mem_valid && r_reg_write;
    assign bus.mem_mem_read   = r_mem_valid && r_mem_read;
    assign bus.mem_mem_write  = r_mem_valid && r_mem_write;
    assign bus.ccr            = r_ccr;
endmodule

// File: tb/tb_ex_mem_ccr_register.sv
// tb_ex_mem_ccr_register: directed stimulus with a transfer scoreboard plus direct CCR/predicate checks.
module tb_ex_mem_ccr_register;
`ifdef FLAG_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [37:0] exp_q[$];
    logic [37:0] exp_e;

    ex_mem_ccr_register_if bus ();

    ex_mem_ccr_register dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pe;
        @(posedge clk);
        #1;
    endtask

    task automatic ne;
        @(negedge clk);
    endtask

    task automatic ex(input logic [15:0] alu, input logic [3:0] st, input logic [3:0] mk, input bit push);
        bus.ex_valid   = 1'b1;
        bus.alu_result = alu;
        bus.store_data = ~alu;
        bus.dst_addr   = alu[2:0];
        bus.reg_write  = 1'b1;
        bus.mem_read   = alu[0];
        bus.mem_write  = alu[1];
        bus.new_status = st;
        bus.flag_mask  = mk;
        if (push) exp_q.push_back({alu, ~alu, alu[2:0], 1'b1, alu[0], alu[1]});
    endtask

    // Scoreboard monitor: every transfer to the memory stage must match the next queued instruction.
    always @(negedge clk) begin
        if (bus.mem_valid && bus.mem_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mem_xfer: unexpected transfer alu=%0h", bus.mem_alu_result);
            end else begin
                exp_e = exp_q.pop_front();
                check("mem_xfer", {bus.mem_alu_result, bus.mem_store_data, bus.mem_dst_addr,
                                   bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write}, exp_e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.ex_valid = 1'b0;
        bus.alu_result = '0;
        bus.new_status = '0;
        bus.flag_mask = '0;
        bus.store_data = '0;
        bus.dst_addr = '0;
        bus.reg_write = 1'b0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.flush = 1'b0;
        bus.int_save = 1'b0;
        bus.rti_restore = 1'b0;
        bus.jmp_cond = 2'b11;
        bus.mem_ready = 1'b1;
        ne;
        check("rst_mem_valid", bus.mem_valid, 0);
        check("rst_ccr", bus.ccr, 0);
        check("rst_ex_ready", bus.ex_ready, 1);
        pe;
        rst_n = 1'b1;
        // ADD with carry, then a JC that consumes C
        ex(16'h001E, 4'b0100, 4'b0111, 1);
        ne;
        check("add_ex_ready", bus.ex_ready, 1);
        pe;
        bus.ex_valid = 1'b0;
        bus.jmp_cond = 2'b10;
        ne;
        check("add_ccr", bus.ccr, 4'b0100);
        check("add_jc_taken", bus.jmp_taken, 1);
        check("add_mem_valid", bus.mem_valid, 1);
        pe;
        bus.jmp_cond = 2'b11;
        ne;
        check("jc_consumed_ccr", bus.ccr, 4'b0000);
        // stall with a pending instruction
        pe;
        ex(16'h0002, 4'b0000, 4'b0000, 1);
        pe;
        ex(16'h0003, 4'b0010, 4'b0111, 0);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ne;
            check("stall_ex_ready", bus.ex_ready, 0);
            check("stall_mem_alu", bus.mem_alu_result, 16'h0002);
            check("stall_mem_valid", bus.mem_valid, 1);
            check("stall_ccr", bus.ccr, 4'b0000);
            pe;
        end
        bus.mem_ready = 1'b1;
        ex(16'h0003, 4'b0010, 4'b0111, 1);
        pe;
        bus.ex_valid = 1'b0;
        ne;
        check("stall_release_alu", bus.mem_alu_result, 16'h0003);
        check("stall_release_ccr", bus.ccr, 4'b0010);
        // flush of a held and an incoming instruction
        pe;
        ex(16'h000C, 4'b0000, 4'b0000, 0);
        pe;
        ex(16'h000D, 4'b0001, 4'b0001, 0);
        bus.flush = 1'b1;
        bus.mem_ready = 1'b0;
        pe;
        bus.flush = 1'b0;
        bus.ex_valid = 1'b0;
        bus.mem_ready = 1'b1;
        ne;
        check("flush_mem_valid", bus.mem_valid, 0);
        check("flush_reg_write", bus.mem_reg_write, 0);
        check("flush_ccr", bus.ccr, 4'b0010);
        // interrupt save / restore / swap
        pe;
        ex(16'h00E1, 4'b1101, 4'b1111, 1);
        pe;
        ex(16'h00F2, 4'b0000, 4'b0111, 1);
        bus.int_save = 1'b1;
        ne;
        check("reserved_bit_ccr", bus.ccr, 4'b0101);
        pe;
        ex(16'h0013, 4'b0010, 4'b0111, 1);
        bus.int_save = 1'b0;
        bus.rti_restore = 1'b1;
        ne;
        check("int_save_ccr", bus.ccr, 4'b0000);
        pe;
        ex(16'h0024, 4'b0010, 4'b0111, 1);
        bus.rti_restore = 1'b0;
        ne;
        check("rti_override_ccr", bus.ccr, 4'b0101);
        pe;
        bus.ex_valid = 1'b0;
        bus.int_save = 1'b1;
        bus.rti_restore = 1'b1;
        ne;
        check("pre_swap_ccr", bus.ccr, 4'b0010);
        pe;
        bus.int_save = 1'b0;
        ne;
        check("swap_ccr", bus.ccr, 4'b0101);
        pe;
        bus.rti_restore = 1'b0;
        ne;
        check("swap_shadow_ccr", bus.ccr, 4'b0010);
        // zero-flag predicate with and without forwarding
        pe;
        ex(16'h0035, 4'b0001, 4'b0001, 1);
        bus.jmp_cond = 2'b00;
        ne;
        check("fwd_jz_taken", bus.jmp_taken, FWD ? 1 : 0);
        pe;
        bus.ex_valid = 1'b0;
        ne;
        check("fwd_ccr", bus.ccr, FWD ? 4'b0010 : 4'b0011);
        check("late_jz_taken", bus.jmp_taken, FWD ? 0 : 1);
        pe;
        bus.jmp_cond = 2'b01;
        ne;
        check("jz_consumed_ccr", bus.ccr, 4'b0010);
        check("jn_taken", bus.jmp_taken, 1);
        pe;
        bus.jmp_cond = 2'b11;
        ne;
        check("jn_consumed_ccr", bus.ccr, 4'b0000);
        check("uncond_taken", bus.jmp_taken, 1);
        // asynchronous reset while stalled
        pe;
        ex(16'h0055, 4'b0100, 4'b0100, 0);
        pe;
        bus.ex_valid = 1'b0;
        bus.mem_ready = 1'b0;
        ne;
        check("prereset_mem_valid", bus.mem_valid, 1);
        check("prereset_ccr", bus.ccr, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_valid", bus.mem_valid, 0);
        check("async_rst_ccr", bus.ccr, 0);
        check("async_rst_reg_write", bus.mem_reg_write, 0);
        check("async_rst_alu", bus.mem_alu_result, 0);
        pe;
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        ne;
        ne;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
